// File: rtl/pipe_reg_hs.sv
// pipe_reg_hs: DEPTH-stage register pipeline with valid/ready handshake per stage,
// bubble collapsing, synchronous flush and registered occupancy count.
// Build option: define PIPE_REG_RESET_DATA_EN to async-reset every payload register to
// RESET_VAL. Without it the payload registers have no reset, and out_data is
// meaningless while out_valid=0.
module pipe_reg_hs #(
    parameter int unsigned       DWIDTH    = 8,
    parameter int unsigned       DEPTH     = 2,
    parameter logic [DWIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DWIDTH-1:0]          in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DWIDTH-1:0]          out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int unsigned OW = $clog2(DEPTH+1);

    if (DWIDTH < 1 || DEPTH < 1 || $bits(RESET_VAL) != DWIDTH) begin : g_param_check
        $error("pipe_reg_hs: DWIDTH and DEPTH must be >= 1");
    end

    logic [DEPTH-1:0]  v;
    logic [DEPTH-1:0]  rdy;
    logic [DEPTH-1:0]  vin;
    logic [DWIDTH-1:0] d   [DEPTH];
    logic [DWIDTH-1:0] din [DEPTH];
    logic              in_xfer;
    logic              out_xfer;

    // Ready chain from the output back to stage 0: a stage may load when it is empty
    // or the stage ahead of it can load (bubble collapse). A scalar carry avoids a
    // self-referencing vector.
    always_comb begin
        logic r;
        r   = out_ready;
        rdy = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            r              = !v[DEPTH-1-i] | r;
            rdy[DEPTH-1-i] = r;
        end
    end

    // Handshake terms and the valid/data offered to each stage.
    always_comb begin
        in_ready = rdy[0] & !flush;
        in_xfer  = in_valid & in_ready;
        out_xfer = v[DEPTH-1] & out_ready;
        vin      = '0;
        vin[0]   = in_xfer;
        din[0]   = in_data;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            vin[i] = v[i-1];
            din[i] = d[i-1];
        end
    end

    // Valid bits: flush clears everything, otherwise each ready stage takes its predecessor's valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v <= '0;
        end else if (flush) begin
            v <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rdy[i]) v[i] <= vin[i];
            end
        end
    end

`ifdef PIPE_REG_RESET_DATA_EN
    // Payload registers with reset: written only when a valid payload moves in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) d[i] <= RESET_VAL;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rdy[i] & vin[i] & !flush) d[i] <= din[i];
            end
        end
    end
`else
    // Payload registers without reset: written only when a valid payload moves in.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (rdy[i] & vin[i] & !flush) d[i] <= din[i];
        end
    end
`endif

    // Occupancy tracks accepted minus delivered payloads; flush empties it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else if (flush) begin
            occupancy <= '0;
        end else if (in_xfer & !out_xfer) begin
            occupancy <= occupancy + OW'(1);
        end else if (!in_xfer & out_xfer) begin
            occupancy <= occupancy - OW'(1);
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Self-checking bench for pipe_reg_hs (DWIDTH=8, DEPTH=3, RESET_VAL=0x5A).
// Reference model: queue of in-flight payloads, each tagged with its stage position.
`timescale 1ns/1ps
module tb_pipe_reg_hs;
    localparam int DW    = 8;
    localparam int DEPTH = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          in_valid  = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data   = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          flush     = 1'b0;
    logic [1:0]    occupancy;

    pipe_reg_hs #(.DWIDTH(DW), .DEPTH(DEPTH), .RESET_VAL(8'h5A)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .occupancy(occupancy)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int            pos;
        logic [DW-1:0] data;
    } item_t;
    item_t q[$];

    // Highest position a newly accepted payload could occupy after this edge (<0: none).
    function automatic int free_limit(input logic ordy);
        int lim;
        int np;
        lim = ordy ? DEPTH : DEPTH - 1;
        foreach (q[k]) begin
            np  = (q[k].pos + 1 < lim) ? q[k].pos + 1 : lim;
            lim = np - 1;
        end
        return lim;
    endfunction

    task automatic model_check(input logic ordy, input logic fl);
        logic exp_ov;
        exp_ov = (q.size() > 0) && (q[0].pos == DEPTH - 1);
        chk("in_ready", in_ready, (!fl && free_limit(ordy) >= 0));
        chk("out_valid", out_valid, exp_ov);
        if (exp_ov) chk("out_data", out_data, q[0].data);
        chk("occupancy", occupancy, q.size());
    endtask

    task automatic model_step(input logic iv, input logic [DW-1:0] id,
                              input logic ordy, input logic fl);
        item_t nq[$];
        item_t it;
        int    lim;
        int    np;
        lim = ordy ? DEPTH : DEPTH - 1;
        foreach (q[k]) begin
            np  = (q[k].pos + 1 < lim) ? q[k].pos + 1 : lim;
            lim = np - 1;
            if (np < DEPTH) begin
                it.pos  = np;
                it.data = q[k].data;
                nq.push_back(it);
            end
        end
        if (iv && !fl && lim >= 0) begin
            it.pos  = 0;
            it.data = id;
            nq.push_back(it);
        end
        if (fl) nq.delete();
        q = nq;
    endtask

    // One clock cycle: drive at negedge, check against model, update model at posedge.
    task automatic apply(input logic iv, input logic [DW-1:0] id,
                         input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
        model_check(ordy, fl);
        @(posedge clk);
        model_step(iv, id, ordy, fl);
        #1;
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic          iv;
        logic [DW-1:0] id;
        logic          ordy;
        logic          fl;
        logic          ir;
        logic          ov;
        logic [DW-1:0] od;
        logic [1:0]    occ;
    } vec_t;
    vec_t tbl[19];

    initial begin
        // Back-to-back stream 0x01..0x10, out_ready=1; expectations are after each edge k.
        for (int k = 0; k < 19; k++) begin
            tbl[k].iv   = (k < 16);
            tbl[k].id   = (k < 16) ? DW'(k + 1) : '0;
            tbl[k].ordy = 1'b1;
            tbl[k].fl   = 1'b0;
            tbl[k].ir   = 1'b1;
            tbl[k].ov   = (k >= 2) && (k <= 17);
            tbl[k].od   = DW'(k - 1);
            tbl[k].occ  = (k < 16) ? ((k + 1 < 3) ? 2'(k + 1) : 2'd3) : 2'(18 - k);
        end

        // Reset state, released between edges.
        #12;
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_occupancy", occupancy, 2'd0);
        chk("rst_in_ready", in_ready, 1'b1);
`ifdef PIPE_REG_RESET_DATA_EN
        chk("rst_out_data", out_data, 8'h5A);
`endif

        for (int k = 0; k < 19; k++) begin
            apply(tbl[k].iv, tbl[k].id, tbl[k].ordy, tbl[k].fl);
            chk("tbl_in_ready", in_ready, tbl[k].ir);
            chk("tbl_out_valid", out_valid, tbl[k].ov);
            if (tbl[k].ov) chk("tbl_out_data", out_data, tbl[k].od);
            chk("tbl_occupancy", occupancy, tbl[k].occ);
        end

        // Fill under backpressure, hold 10 cycles, then release.
        apply(1'b1, 8'hA1, 1'b0, 1'b0);
        apply(1'b1, 8'hA2, 1'b0, 1'b0);
        apply(1'b1, 8'hA3, 1'b0, 1'b0);
        chk("full_occupancy", occupancy, 2'd3);
        for (int k = 0; k < 10; k++) begin
            apply(1'b1, 8'hA4, 1'b0, 1'b0);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_out_data", out_data, 8'hA1);
        end
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        chk("release_1", out_data, 8'hA2);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        chk("release_2", out_data, 8'hA3);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        chk("release_end", out_valid, 1'b0);

        // Bubble collapse with out_ready=0.
        apply(1'b1, 8'h11, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b0);
        apply(1'b1, 8'h22, 1'b0, 1'b0);
        apply(1'b0, 8'h00, 1'b0, 1'b0);
        chk("bubble_occupancy", occupancy, 2'd2);
        chk("bubble_in_ready", in_ready, 1'b1);
        chk("bubble_out_data", out_data, 8'h11);
        apply(1'b0, 8'h00, 1'b1, 1'b0);
        chk("bubble_second", out_data, 8'h22);
        apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Full with simultaneous in/out transfers for 20 cycles.
        for (int k = 0; k < 3; k++) apply(1'b1, DW'(8'hC0 + k), 1'b0, 1'b0);
        for (int k = 0; k < 20; k++) begin
            apply(1'b1, DW'($urandom), 1'b1, 1'b0);
            chk("sustain_occupancy", occupancy, 2'd3);
        end
        for (int k = 0; k < 4; k++) apply(1'b0, 8'h00, 1'b1, 1'b0);

        // Flush while full and stalled.
        for (int k = 0; k < 3; k++) apply(1'b1, DW'(8'hB1 + k), 1'b0, 1'b0);
        apply(1'b1, 8'hEE, 1'b0, 1'b1);
        chk("flush_in_ready", in_ready, 1'b0);
        chk("flush_out_valid", out_valid, 1'b0);
        chk("flush_occupancy", occupancy, 2'd0);
        for (int k = 0; k < 4; k++) begin
            apply(1'b0, 8'h00, 1'b1, 1'b0);
            chk("flush_no_emit", out_valid, 1'b0);
        end

        // Asynchronous reset between edges with two payloads in flight.
        apply(1'b1, 8'hD1, 1'b0, 1'b0);
        apply(1'b1, 8'hD2, 1'b0, 1'b0);
        chk("pre_rst_occupancy", occupancy, 2'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 1'b0);
        chk("arst_occupancy", occupancy, 2'd0);
        chk("arst_in_ready", in_ready, 1'b1);
`ifdef PIPE_REG_RESET_DATA_EN
        chk("arst_out_data", out_data, 8'h5A);
`endif
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();

        // Randomised traffic against the model.
        for (int k = 0; k < 400; k++) begin
            apply(1'($urandom_range(0, 1)), DW'($urandom),
                  ($urandom_range(0, 9) < 7), ($urandom_range(0, 19) == 0));
        end
        for (int k = 0; k < 5; k++) apply(1'b0, 8'h00, 1'b1, 1'b0);
        chk("final_empty", occupancy, 2'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
